// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit for the multi-cycle RV32I core. Accepts one
//            LOAD/STORE per transaction, performs it on a private byte-lane
//            data RAM and returns a sign/zero-extended load result.
//            Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned
//            halfword/word accesses fault instead of being force-aligned).
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int    AW        = 10,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic          store_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [0:(2**AW)-1];
  logic [31:0]   rword;

  logic          funct3_bad;
  logic          range_bad;
  logic          misalign;
  logic          err;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   rdata_fmt;

  assign widx      = addr_q[AW+1:2];
  assign req_ready = (state == IDLE);

  // Fault classification from the latched request (stable through ACCESS/RESP)
  always_comb begin
    if (store_q)
      funct3_bad = !(funct3_q inside {3'b000, 3'b001, 3'b010});
    else
      funct3_bad = !(funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    range_bad = |addr_q[31:AW+2];
    misalign  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (funct3_q[1:0])
      2'b01:   misalign = addr_q[0];
      2'b10:   misalign = |addr_q[1:0];
      default: misalign = 1'b0;
    endcase
`endif
    err = funct3_bad | range_bad | misalign;
  end

  // Store lane enables and replicated write data; only live on a clean store in ACCESS
  always_comb begin
    be    = 4'b0000;
    wword = wdata_q;
    case (funct3_q)
      3'b000: begin
        be[addr_q[1:0]] = 1'b1;
        wword           = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!((state == ACCESS) && store_q && !err)) be = 4'b0000;
  end

  // Data RAM: byte-lane write and word read, both on the ACCESS edge
  always_ff @(posedge clk) begin
    if (state == ACCESS) rword <= mem[widx];
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

  // Load result formatting: lane select plus sign/zero extension
  always_comb begin
    byte_sel = rword[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? rword[31:16] : rword[15:0];
    case (funct3_q)
      3'b000:  rdata_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  rdata_fmt = {{16{half_sel[15]}}, half_sel};
      3'b010:  rdata_fmt = rword;
      3'b100:  rdata_fmt = {24'd0, byte_sel};
      3'b101:  rdata_fmt = {16'd0, half_sel};
      default: rdata_fmt = 32'd0;
    endcase
    if (store_q || err) rdata_fmt = 32'd0;
  end

  // Transaction FSM with registered response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      store_q    <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            state    <= ACCESS;
          end
        end
        ACCESS: state <= RESP;
        RESP: begin
          resp_valid <= 1'b1;
          resp_err   <= err;
          resp_rdata <= rdata_fmt;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Directed self-checking bench for lsu (one task per scenario).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks;
  int errors;

  lsu #(.AW(10), .INIT_FILE("")) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction; reports the response, its latency after accept,
  // whether req_ready stayed low while busy, and whether the pulse lasted one cycle.
  task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat, output logic busy_ok, output logic pulse_ok);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_wdata  = 32'hXXXX_XXXX;
    req_addr   = 32'hFFFF_FFFF;
    busy_ok    = !req_ready;
    lat        = -1;
    rd         = 32'hDEAD_0000;
    er         = 1'bx;
    pulse_ok   = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i;
        rd  = resp_rdata;
        er  = resp_err;
        break;
      end
      if (req_ready) busy_ok = 1'b0;
    end
    if (lat > 0) begin
      @(negedge clk);
      pulse_ok = !resp_valid;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_funct3 = 3'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", resp_err); end
    reset = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd; logic er, b, p; int lat; bit seen;
    xact(1'b1, 3'b010, 32'h40, 32'h1234_5678, rd, er, lat, b, p);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #2 reset = 1'b1; req_valid = 1'b0;
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_noresp got=%b exp=0", seen); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", req_ready); end
    xact(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, b, p);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL midreset_lw got=%h exp=12345678", rd); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er, b, p; int lat;
    xact(1'b1, 3'b010, 32'h10, 32'h1122_3344, rd, er, lat, b, p);
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL sw_resp got=%h/%b exp=0/0", rd, er); end
    xact(1'b1, 3'b000, 32'h12, 32'hFFFF_FFAA, rd, er, lat, b, p);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, b, p);
    checks++; if (rd !== 32'h11AA_3344) begin errors++; $display("FAIL lw_after_sb got=%h exp=11aa3344", rd); end
    xact(1'b0, 3'b000, 32'h12, 32'h0, rd, er, lat, b, p);
    checks++; if (rd !== 32'hFFFF_FFAA) begin errors++; $display("FAIL lb got=%h exp=ffffffaa", rd); end
    xact(1'b0, 3'b100, 32'h12, 32'h0, rd, er, lat, b, p);
    checks++; if (rd !== 32'h0000_00AA) begin errors++; $display("FAIL lbu got=%h exp=000000aa", rd); end
    xact(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat, b, p);
    checks++; if (rd !== 32'h0000_0011) begin errors++; $display("FAIL lbu_lane3 got=%h exp=00000011", rd); end
  endtask

  task automatic test_halfword();
    logic [31:0] rd; logic er, b, p; int lat;
    xact(1'b1, 3'b010, 32'h20, 32'h0, rd, er, lat, b, p);
    xact(1'b1, 3'b001, 32'h22, 32'hCAFE_8001, rd, er, lat, b, p);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sh_latency got=%0d exp=2", lat); end
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL sh_ready_low got=%b exp=1", b); end
    xact(1'b0, 3'b001, 32'h22, 32'h0, rd, er, lat, b, p);
    checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh got=%h exp=ffff8001", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lh_latency got=%0d exp=2", lat); end
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL lh_ready_low got=%b exp=1", b); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL lh_pulse_one got=%b exp=1", p); end
    xact(1'b0, 3'b101, 32'h22, 32'h0, rd, er, lat, b, p);
    checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu got=%h exp=00008001", rd); end
    xact(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, b, p);
    checks++; if (rd !== 32'h8001_0000) begin errors++; $display("FAIL sh_lanes got=%h exp=80010000", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, b, p; int lat;
    xact(1'b1, 3'b010, 32'h0, 32'h0BAD_F00D, rd, er, lat, b, p);
    xact(1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat, b, p);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL range_lw got=%h/%b exp=0/1", rd, er); end
    xact(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat, b, p);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL funct3_011 got=%h/%b exp=0/1", rd, er); end
    xact(1'b1, 3'b100, 32'h0, 32'hFFFF_FFFF, rd, er, lat, b, p);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL store_f3_100 got=%b exp=1", er); end
    xact(1'b1, 3'b010, 32'h1000, 32'hFFFF_FFFF, rd, er, lat, b, p);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_sw got=%b exp=1", er); end
    xact(1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat, b, p);
    checks++; if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin errors++; $display("FAIL ram_unchanged got=%h/%b exp=0badf00d/0", rd, er); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er, b, p; int lat;
    xact(1'b0, 3'b010, 32'h13, 32'h0, rd, er, lat, b, p);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL misalign_lw got=%h/%b exp=0/1", rd, er); end
`else
    checks++; if (er !== 1'b0 || rd !== 32'h11AA_3344) begin errors++; $display("FAIL misalign_lw got=%h/%b exp=11aa3344/0", rd, er); end
`endif
    xact(1'b0, 3'b001, 32'h23, 32'h0, rd, er, lat, b, p);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL misalign_lh got=%h/%b exp=0/1", rd, er); end
`else
    checks++; if (er !== 1'b0 || rd !== 32'hFFFF_8001) begin errors++; $display("FAIL misalign_lh got=%h/%b exp=ffff8001/0", rd, er); end
`endif
  endtask

  task automatic test_back_to_back();
    int          acc[$];
    logic [31:0] rsp[$];
    int          idx;
    @(negedge clk);
    for (int c = 0; c < 14; c++) begin
      if (c < 10) begin
        idx = acc.size() % 4;
        req_valid  = 1'b1;
        req_store  = (idx % 2 == 0);
        req_funct3 = 3'b010;
        req_addr   = (idx < 2) ? 32'h80 : 32'h84;
        req_wdata  = (idx < 2) ? 32'hA5A5_0001 : 32'h5A5A_0002;
      end else begin
        req_valid = 1'b0;
      end
      if (resp_valid) rsp.push_back(resp_rdata);
      if (c < 10 && req_ready) acc.push_back(c);
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++; if (acc.size() !== 4) begin errors++; $display("FAIL b2b_accepts got=%0d exp=4", acc.size()); end
    if (acc.size() == 4) begin
      checks++;
      if (acc[0] !== 0 || acc[1] !== 3 || acc[2] !== 6 || acc[3] !== 9) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d,%0d,%0d,%0d exp=0,3,6,9", acc[0], acc[1], acc[2], acc[3]);
      end
    end
    checks++; if (rsp.size() !== 4) begin errors++; $display("FAIL b2b_responses got=%0d exp=4", rsp.size()); end
    if (rsp.size() == 4) begin
      checks++; if (rsp[1] !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_load1 got=%h exp=a5a50001", rsp[1]); end
      checks++; if (rsp[3] !== 32'h5A5A_0002) begin errors++; $display("FAIL b2b_load2 got=%h exp=5a5a0002", rsp[3]); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_midflight();
    test_byte_lanes();
    test_halfword();
    test_errors();
    test_misalign();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
